// File: rtl/hbridge_gate_driver.sv
// Purpose: H-bridge gate driver: direction FSM, dead time, shoot-through lockout; `HBRIDGE_SYNC_RECT_EN` adds synchronous rectification.
// Latency: gates, fault and state are registered and reflect the inputs sampled at the preceding clk edge.
// Backpressure: none; pwm_fwd/pwm_rev are consumed every cycle, no handshake.
module hbridge_gate_driver #(
    parameter int DEAD_CYC = 4,
    parameter int HOLD_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_fwd,
    input  logic       pwm_rev,
    output logic       ha,
    output logic       la,
    output logic       hb,
    output logic       lb,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_FWD   = 3'd1,
        ST_REV   = 3'd2,
        ST_DEAD  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    // Last count value of each timer before it fires.
    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYC - 1);

    state_t     cur_st;
    state_t     nxt_st;
    state_t     tgt_st;
    state_t     tgt_nxt;
    logic [7:0] dead_cnt;
    logic [7:0] hold_cnt;
    logic       fwd_req;
    logic       rev_req;
    logic       both;
    logic       idle;
    logic       drive;
    logic       hold_expired;
    logic       ha_nxt;
    logic       la_nxt;
    logic       hb_nxt;
    logic       lb_nxt;

    assign fwd_req      = pwm_fwd & ~pwm_rev;
    assign rev_req      = pwm_rev & ~pwm_fwd;
    assign both         = pwm_fwd & pwm_rev;
    assign idle         = ~pwm_fwd & ~pwm_rev;
    assign drive        = (cur_st == ST_FWD) || (cur_st == ST_REV);
    // hold_cnt counts earlier idle samples, so the current idle one is the HOLD_CYC-th.
    assign hold_expired = drive && idle && (hold_cnt >= HOLD_LAST);
    assign state        = cur_st;

    // State and dead-band target registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_st <= ST_COAST;
            tgt_st <= ST_COAST;
        end else begin
            cur_st <= nxt_st;
            tgt_st <= tgt_nxt;
        end
    end

    // Next-state decode; both-high wins over every other request.
    always_comb begin
        nxt_st  = cur_st;
        tgt_nxt = tgt_st;
        case (cur_st)
            ST_COAST: begin
                if (both)         nxt_st = ST_FAULT;
                else if (fwd_req) nxt_st = ST_FWD;
                else if (rev_req) nxt_st = ST_REV;
            end
            ST_FWD: begin
                if (both) begin
                    nxt_st = ST_FAULT;
                end else if (rev_req) begin
                    nxt_st  = ST_DEAD;
                    tgt_nxt = ST_REV;
                end else if (hold_expired) begin
                    nxt_st  = ST_DEAD;
                    tgt_nxt = ST_COAST;
                end
            end
            ST_REV: begin
                if (both) begin
                    nxt_st = ST_FAULT;
                end else if (fwd_req) begin
                    nxt_st  = ST_DEAD;
                    tgt_nxt = ST_FWD;
                end else if (hold_expired) begin
                    nxt_st  = ST_DEAD;
                    tgt_nxt = ST_COAST;
                end
            end
            ST_DEAD: begin
                if (both)                       nxt_st = ST_FAULT;
                else if (dead_cnt == DEAD_LAST) nxt_st = tgt_st;
            end
            ST_FAULT: begin
                if (idle) begin
                    nxt_st  = ST_DEAD;
                    tgt_nxt = ST_COAST;
                end
            end
            default: nxt_st = ST_COAST;
        endcase
    end

    // Dead-band length counter and idle-hold counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dead_cnt <= '0;
            hold_cnt <= '0;
        end else begin
            dead_cnt <= (cur_st == ST_DEAD && nxt_st == ST_DEAD) ? dead_cnt + 8'd1 : 8'd0;
            if (drive && idle)
                hold_cnt <= (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
            else
                hold_cnt <= '0;
        end
    end

`ifdef HBRIDGE_SYNC_RECT_EN
    // Run length of the driven PWM level; a switch may turn on only after DEAD_CYC+1 equal samples.
    localparam logic [8:0] RUN_MIN = 9'(DEAD_CYC + 1);

    logic       drv_pwm;
    logic       run_lvl;
    logic       run_ok;
    logic [8:0] run_cnt;
    logic [8:0] run_now;

    // Run length including the current sample; restarts on level change or state entry.
    always_comb begin
        drv_pwm = (nxt_st == ST_REV) ? pwm_rev : pwm_fwd;
        run_now = 9'd1;
        if (nxt_st == cur_st && drv_pwm == run_lvl)
            run_now = (run_cnt >= RUN_MIN) ? run_cnt : run_cnt + 9'd1;
        run_ok = (run_now >= RUN_MIN);
    end

    // Run-length tracker, cleared whenever the bridge is not driving.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            run_cnt <= '0;
            run_lvl <= 1'b0;
        end else begin
            run_cnt <= (nxt_st == ST_FWD || nxt_st == ST_REV) ? run_now : 9'd0;
            run_lvl <= drv_pwm;
        end
    end
`endif

    // Gate decode from the state being entered; only one side of each leg can be set.
    always_comb begin
        ha_nxt = 1'b0;
        la_nxt = 1'b0;
        hb_nxt = 1'b0;
        lb_nxt = 1'b0;
        case (nxt_st)
            ST_FWD: begin
                lb_nxt = 1'b1;
`ifdef HBRIDGE_SYNC_RECT_EN
                ha_nxt = pwm_fwd & run_ok;
                la_nxt = ~pwm_fwd & run_ok;
`else
                ha_nxt = pwm_fwd;
`endif
            end
            ST_REV: begin
                la_nxt = 1'b1;
`ifdef HBRIDGE_SYNC_RECT_EN
                hb_nxt = pwm_rev & run_ok;
                lb_nxt = ~pwm_rev & run_ok;
`else
                hb_nxt = pwm_rev;
`endif
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ha    <= 1'b0;
            la    <= 1'b0;
            hb    <= 1'b0;
            lb    <= 1'b0;
            fault <= 1'b0;
        end else begin
            ha    <= ha_nxt;
            la    <= la_nxt;
            hb    <= hb_nxt;
            lb    <= lb_nxt;
            fault <= (nxt_st == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_hbridge_gate_driver.sv
// Purpose: self-checking bench for hbridge_gate_driver against a behavioural model.
// Latency: model updates on each rising edge, outputs compared on each falling edge.
// Backpressure: none; stimulus is applied on falling edges.
module tb_hbridge_gate_driver;

    localparam int DEAD = 4;
    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_fwd = 1'b0;
    logic       pwm_rev = 1'b0;
    logic       ha, la, hb, lb, fault;
    logic [2:0] state;

    int vectors = 0;
    int miscompares = 0;

    hbridge_gate_driver #(.DEAD_CYC(DEAD), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_fwd (pwm_fwd),
        .pwm_rev (pwm_rev),
        .ha      (ha),
        .la      (la),
        .hb      (hb),
        .lb      (lb),
        .fault   (fault),
        .state   (state)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 coast, 1 fwd, 2 rev, 3 dead, 4 fault.
    int m_st = 0;
    int m_tgt = 0;
    int m_low = 0;
    int m_dead_left = 0;
    bit m_hist[$];
    bit m_ha, m_la, m_hb, m_lb, m_fault;
    bit chk_en = 1'b0;

    task automatic go_dead(input int tgt);
        m_st        = 3;
        m_tgt       = tgt;
        m_dead_left = DEAD;
    endtask

    // True when the last DEAD+1 samples since entering the drive state all equal lvl.
    function automatic bit steady(input bit lvl);
        if (m_hist.size() < DEAD + 1) return 1'b0;
        foreach (m_hist[i]) if (m_hist[i] != lvl) return 1'b0;
        return 1'b1;
    endfunction

    // Model advance on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        bit pf, pr, bo, idle;
        int prev;
        pf   = pwm_fwd;
        pr   = pwm_rev;
        bo   = pf & pr;
        idle = ~pf & ~pr;
        if (!rst_n) begin
            m_st = 0;
            m_low = 0;
            m_hist.delete();
            chk_en = 1'b1;
        end else begin
            prev = m_st;
            case (m_st)
                0: begin
                    if (bo)      m_st = 4;
                    else if (pf) m_st = 1;
                    else if (pr) m_st = 2;
                end
                1, 2: begin
                    if (bo) m_st = 4;
                    else if (m_st == 1 && pr) go_dead(2);
                    else if (m_st == 2 && pf) go_dead(1);
                    else if (idle) begin
                        m_low++;
                        if (m_low == HOLD) go_dead(0);
                    end else m_low = 0;
                end
                3: begin
                    if (bo) m_st = 4;
                    else begin
                        m_dead_left--;
                        if (m_dead_left == 0) m_st = m_tgt;
                    end
                end
                default: if (idle) go_dead(0);
            endcase
            if (m_st != prev) begin
                m_hist.delete();
                m_low = 0;
            end
            if (m_st == 1) m_hist.push_back(pf);
            else if (m_st == 2) m_hist.push_back(pr);
            if (m_hist.size() > DEAD + 1) void'(m_hist.pop_front());
        end
        m_ha = 0; m_la = 0; m_hb = 0; m_lb = 0;
        m_fault = (m_st == 4);
        if (m_st == 1) begin
            m_lb = 1;
`ifdef HBRIDGE_SYNC_RECT_EN
            m_ha = steady(1'b1);
            m_la = steady(1'b0);
`else
            m_ha = pf;
`endif
        end else if (m_st == 2) begin
            m_la = 1;
`ifdef HBRIDGE_SYNC_RECT_EN
            m_hb = steady(1'b1);
            m_lb = steady(1'b0);
`else
            m_hb = pf ? 1'b0 : pr;
`endif
        end
    end

    // Per-cycle comparison of every output against the model, plus the shoot-through invariant.
    always @(negedge clk) begin
        if (chk_en) begin
            vectors++;
            if ({ha, la, hb, lb, fault, state} !== {m_ha, m_la, m_hb, m_lb, m_fault, 3'(m_st)}) begin
                miscompares++;
                $display("FAIL cycle_cmp t=%0t dut ha,la,hb,lb=%b%b%b%b fault=%b state=%0d model ha,la,hb,lb=%b%b%b%b fault=%b state=%0d",
                         $time, ha, la, hb, lb, fault, state, m_ha, m_la, m_hb, m_lb, m_fault, m_st);
            end
            vectors++;
            if ((ha & la) !== 1'b0 || (hb & lb) !== 1'b0) begin
                miscompares++;
                $display("FAIL overlap t=%0t ha,la,hb,lb=%b%b%b%b required no leg overlap", $time, ha, la, hb, lb);
            end
        end
    end

    task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t got %0d required %0d", name, $time, act, exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ha_cnt, la_first, mode, len, per, duty;
        bit p;

        // Reset held three edges with pwm_fwd high.
        rst_n = 1'b0; pwm_fwd = 1'b1; pwm_rev = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("rst_gates", {ha, la, hb, lb}, 0);
        check_lit("rst_state", state, 0);
        check_lit("rst_fault", fault, 0);

        // Forward 25% duty.
        rst_n = 1'b1;
        for (int c = 0; c < 24; c++) begin
            pwm_fwd = ((c % 8) < 2);
            pwm_rev = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                check_lit("fwd_state", state, 1);
                check_lit("fwd_lb", lb, 1);
            end
`ifdef HBRIDGE_SYNC_RECT_EN
            if (c == 1) check_lit("fwd_ha_short", ha, 0);
`else
            if (c == 1) check_lit("fwd_ha_follow", ha, 1);
`endif
            if (c == 2) check_lit("fwd_ha_low", {ha, hb}, 0);
        end

        // Reversal: dead band of DEAD cycles, then REV.
        pwm_fwd = 1'b0; pwm_rev = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_lit("rev_state", state, (k < 4) ? 3 : 2);
            check_lit("rev_model_state", m_st, (k < 4) ? 3 : 2);
            if (k < 4) check_lit("rev_dead_gates", {ha, la, hb, lb}, 0);
            else       check_lit("rev_la", la, 1);
        end
        repeat (3) @(negedge clk);

        // Shoot-through request in REV.
        pwm_fwd = 1'b1; pwm_rev = 1'b1;
        @(negedge clk);
        check_lit("st_state", state, 4);
        check_lit("st_fault", fault, 1);
        check_lit("st_gates", {ha, la, hb, lb}, 0);
        pwm_fwd = 1'b0; pwm_rev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_lit("st_exit_state", state, (k < 4) ? 3 : 0);
        end

        // Hold timeout from FWD.
        pwm_fwd = 1'b1;
        repeat (3) @(negedge clk);
        pwm_fwd = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 15) check_lit("hold_before", state, 1);
            if (k == 16) check_lit("hold_dead", state, 3);
            if (k == 19) check_lit("hold_dead_end", state, 3);
            if (k == 20) check_lit("hold_coast", state, 0);
        end

        // Ten-cycle high pulse from COAST.
        ha_cnt = 0; la_first = -1;
        for (int idx = 0; idx < 20; idx++) begin
            pwm_fwd = (idx < 10);
            @(negedge clk);
            if (ha === 1'b1) ha_cnt++;
            if (la === 1'b1 && la_first < 0) la_first = idx;
        end
`ifdef HBRIDGE_SYNC_RECT_EN
        check_lit("pulse10_ha_cycles", ha_cnt, 6);
        check_lit("pulse10_la_rise", la_first, 14);
`else
        check_lit("pulse10_ha_cycles", ha_cnt, 10);
        check_lit("pulse10_la_rise", la_first, 32'hFFFF_FFFF);
`endif
        repeat (10) @(negedge clk);
        check_lit("pulse10_coast", state, 0);

        // Three-cycle pulse.
        ha_cnt = 0;
        for (int idx = 0; idx < 10; idx++) begin
            pwm_fwd = (idx < 3);
            @(negedge clk);
            if (ha === 1'b1) ha_cnt++;
        end
`ifdef HBRIDGE_SYNC_RECT_EN
        check_lit("pulse3_ha_cycles", ha_cnt, 0);
`else
        check_lit("pulse3_ha_cycles", ha_cnt, 3);
`endif
        repeat (20) @(negedge clk);

        // Randomized segments: PWM either way, overlaps, long idles, resets.
        for (int s = 0; s < 150; s++) begin
            mode = $urandom_range(0, 9);
            len  = $urandom_range(8, 40);
            per  = $urandom_range(3, 16);
            duty = $urandom_range(0, per);
            for (int c = 0; c < len; c++) begin
                p = ((c % per) < duty);
                rst_n = 1'b1; pwm_fwd = 1'b0; pwm_rev = 1'b0;
                case (mode)
                    0, 1, 2, 3: pwm_fwd = p;
                    4, 5, 6:    pwm_rev = p;
                    7: begin
                        pwm_fwd = p;
                        pwm_rev = ($urandom_range(0, 3) == 0);
                    end
                    8: ;
                    default: begin
                        rst_n   = (c >= 2);
                        pwm_rev = p;
                    end
                endcase
                @(negedge clk);
            end
        end

        rst_n = 1'b1; pwm_fwd = 1'b0; pwm_rev = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
